// File: rtl/ntt_mem_pkg.sv
// Shared types and address helpers for the banked NTT coefficient memory.
package ntt_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Low address bits pick the bank so consecutive coefficients land in different banks.
  function automatic int unsigned bank_of(input logic [31:0] addr, input int bbits);
    return int'(addr & ((32'd1 << bbits) - 32'd1));
  endfunction

  function automatic int unsigned row_of(input logic [31:0] addr, input int bbits);
    return int'(addr >> bbits);
  endfunction

endpackage

// File: rtl/ntt_sdp_bank.sv
// One simple dual-port bank: one write and one synchronous read per cycle.
module ntt_sdp_bank #(
  parameter int width = 32,
  parameter int len   = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [len-1:0]   waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [len-1:0]   raddr,
  output logic [width-1:0] rdata
);

  (* ram_style = "block" *) logic [width-1:0] mem [1<<len];

  // NOTE: the array has no reset so it maps onto block RAM; the clear engine zero-fills it instead.
  // NOTE: non-blocking write and read in one process give read-old-data on a same-row collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ntt_banked_ram.sv
// Banked 2R/2W coefficient memory: port steering, arbitration, forwarding, read pipeline, clear FSM.
module ntt_banked_ram
  import ntt_mem_pkg::*;
#(
  parameter int width      = 32,
  parameter int len        = 9,
  parameter int NBANK      = 2,
  parameter int RD_LAT     = 1,
  parameter int WR_FIRST   = 1,
  parameter int INIT_CLEAR = 1,
  localparam int AW        = len + $clog2(NBANK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             ready,
  input  logic             wen_a,
  input  logic             wen_b,
  input  logic [AW-1:0]    waddr_a,
  input  logic [AW-1:0]    waddr_b,
  input  logic [width-1:0] din_a,
  input  logic [width-1:0] din_b,
  input  logic             ren_a,
  input  logic             ren_b,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [width-1:0] dout_a,
  output logic [width-1:0] dout_b,
  output logic             rvalid_a,
  output logic             rvalid_b,
  output logic             wr_conflict,
  output logic             rd_conflict,
  input  logic             conflict_clr
);

  localparam int BBITS = $clog2(NBANK);
  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

  state_t state, state_n;
  logic [len-1:0] cnt, cnt_n;

  logic [BBITS-1:0] wbank_a, wbank_b, rbank_a, rbank_b;
  logic [len-1:0]   wrow_a, wrow_b, rrow_a, rrow_b;
  logic wr_clash, rd_clash, wa_ok, wb_ok, ra_ok, rb_ok;
  logic fwd_a, fwd_b;
  logic [width-1:0] fdata_a, fdata_b;

  logic             bank_we    [NBANK];
  logic [len-1:0]   bank_waddr [NBANK];
  logic [width-1:0] bank_wdata [NBANK];
  logic             bank_re    [NBANK];
  logic [len-1:0]   bank_raddr [NBANK];
  logic [width-1:0] bank_rdata [NBANK];

  assign wbank_a = BBITS'(bank_of(32'(waddr_a), BBITS));
  assign wbank_b = BBITS'(bank_of(32'(waddr_b), BBITS));
  assign rbank_a = BBITS'(bank_of(32'(raddr_a), BBITS));
  assign rbank_b = BBITS'(bank_of(32'(raddr_b), BBITS));
  assign wrow_a  = len'(row_of(32'(waddr_a), BBITS));
  assign wrow_b  = len'(row_of(32'(waddr_b), BBITS));
  assign rrow_a  = len'(row_of(32'(raddr_a), BBITS));
  assign rrow_b  = len'(row_of(32'(raddr_b), BBITS));

  // Port A always wins a bank collision; B is dropped and flagged.
  assign wr_clash = ready & wen_a & wen_b & (wbank_a == wbank_b);
  assign rd_clash = ready & ren_a & ren_b & (rbank_a == rbank_b);
  assign wa_ok    = ready & wen_a;
  assign wb_ok    = ready & wen_b & ~wr_clash;
  assign ra_ok    = ready & ren_a;
  assign rb_ok    = ready & ren_b & ~rd_clash;

  // Same-cycle write to the read address bypasses the bank (write-first mode only).
  assign fwd_a   = (WR_FIRST != 0) && ((wa_ok && waddr_a == raddr_a) || (wb_ok && waddr_b == raddr_a));
  assign fwd_b   = (WR_FIRST != 0) && ((wa_ok && waddr_a == raddr_b) || (wb_ok && waddr_b == raddr_b));
  assign fdata_a = (wa_ok && waddr_a == raddr_a) ? din_a : din_b;
  assign fdata_b = (wa_ok && waddr_a == raddr_b) ? din_a : din_b;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      bank_we[b]    = 1'b0;
      bank_waddr[b] = wrow_a;
      bank_wdata[b] = din_a;
      bank_re[b]    = 1'b0;
      bank_raddr[b] = rrow_a;
      if (state == CLEAR) begin
        bank_we[b]    = 1'b1;
        bank_waddr[b] = cnt;
        bank_wdata[b] = '0;
      end else if (wa_ok && wbank_a == BBITS'(b)) begin
        bank_we[b] = 1'b1;
      end else if (wb_ok && wbank_b == BBITS'(b)) begin
        bank_we[b]    = 1'b1;
        bank_waddr[b] = wrow_b;
        bank_wdata[b] = din_b;
      end
      if (ra_ok && rbank_a == BBITS'(b)) begin
        bank_re[b] = 1'b1;
      end else if (rb_ok && rbank_b == BBITS'(b)) begin
        bank_re[b]    = 1'b1;
        bank_raddr[b] = rrow_b;
      end
    end
  end

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    ntt_sdp_bank #(.width(width), .len(len)) u_bank (
      .clk  (clk),
      .we   (bank_we[g]),
      .waddr(bank_waddr[g]),
      .wdata(bank_wdata[g]),
      .re   (bank_re[g]),
      .raddr(bank_raddr[g]),
      .rdata(bank_rdata[g])
    );
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      CLEAR: begin
        cnt_n = cnt + 1'b1;
        if (&cnt) state_n = READY;
      end
      READY: begin
        if (clr_req && ready) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      default: state_n = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_STATE;
      cnt         <= '0;
      ready       <= 1'b0;
      wr_conflict <= 1'b0;
      rd_conflict <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ready <= (state_n == READY);
      if (wr_clash)          wr_conflict <= 1'b1;
      else if (conflict_clr) wr_conflict <= 1'b0;
      if (rd_clash)          rd_conflict <= 1'b1;
      else if (conflict_clr) rd_conflict <= 1'b0;
    end
  end

  // Stage 1 tracks which bank (or bypass) feeds each port when bank data appears.
  logic             rv1_a, rv1_b, fwd1_a, fwd1_b;
  logic [BBITS-1:0] sel1_a, sel1_b;
  logic [width-1:0] fdata1_a, fdata1_b, d1_a, d1_b, hold_a, hold_b;
  logic             rv2_a, rv2_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv1_a <= 1'b0;  rv1_b <= 1'b0;
      fwd1_a <= 1'b0; fwd1_b <= 1'b0;
      sel1_a <= '0;   sel1_b <= '0;
      fdata1_a <= '0; fdata1_b <= '0;
    end else begin
      rv1_a <= ra_ok; rv1_b <= rb_ok;
      fwd1_a <= fwd_a; fwd1_b <= fwd_b;
      sel1_a <= rbank_a; sel1_b <= rbank_b;
      fdata1_a <= fdata_a; fdata1_b <= fdata_b;
    end
  end

  assign d1_a = fwd1_a ? fdata1_a : bank_rdata[sel1_a];
  assign d1_b = fwd1_b ? fdata1_b : bank_rdata[sel1_b];

  // hold_* keeps the last valid word; with RD_LAT=2 it is also the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a <= '0;  hold_b <= '0;
      rv2_a  <= 1'b0; rv2_b <= 1'b0;
    end else begin
      if (rv1_a) hold_a <= d1_a;
      if (rv1_b) hold_b <= d1_b;
      rv2_a <= rv1_a;
      rv2_b <= rv1_b;
    end
  end

  if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
    assign dout_a   = hold_a;
    assign dout_b   = hold_b;
    assign rvalid_a = rv2_a;
    assign rvalid_b = rv2_b;
  end else begin : g_lat1
    assign dout_a   = rv1_a ? d1_a : hold_a;
    assign dout_b   = rv1_b ? d1_b : hold_b;
    assign rvalid_a = rv1_a;
    assign rvalid_b = rv1_b;
  end

endmodule
